// File: rtl/voice_bus_regs.sv
// voice_bus_regs: bus responder for one synth voice.
//
// Brings the asynchronous parallel register bus (BusAddress/BusData/BusReadWrite/BusClock)
// into the Clock domain. It decodes a 4-register window at BASE_ADDR..BASE_ADDR+3 and holds
// the voice control registers. It also emits one-cycle gate edge events for the
// envelope/oscillator.
//
// Register map (offset from BASE_ADDR):
//   0  Incr        [7:0] phase increment
//   1  Gate        [0]   gate level
//   2  WaveType    [1:0] waveform select
//   3  PulseWidth  [7:0] square duty (reset PW_RESET)
//
// Ports:
//   Clock        in    system clock, rising edge
//   Reset        in    asynchronous, active-high
//   BusAddress   in    register address, async to Clock
//   BusData      inout write data in; readback out when enabled, otherwise Z
//   BusReadWrite in    1 = write, 0 = read
//   BusClock     in    transaction strobe, commit on rising edge
//   Incr, Gate, WaveType, PulseWidth  out  register contents
//   GateOn / GateOff  out  one-Clock pulse on Gate 0->1 / 1->0
//   WriteStrobe       out  one-Clock pulse per accepted write
//
// Optional feature: define VOICE_BUS_READBACK_EN to drive register readback onto BusData
// while a read to the window is strobed. Without it BusData is never driven.
module voice_bus_regs #(
  parameter logic [15:0] BASE_ADDR = 16'h0010,
  parameter logic [7:0]  PW_RESET  = 8'h80
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] BusAddress,
  inout  wire  [7:0]  BusData,
  input  logic        BusReadWrite,
  input  logic        BusClock,
  output logic [7:0]  Incr,
  output logic        Gate,
  output logic [1:0]  WaveType,
  output logic [7:0]  PulseWidth,
  output logic        GateOn,
  output logic        GateOff,
  output logic        WriteStrobe
);

  // True when addr lies in BASE_ADDR..BASE_ADDR+3 (full 16-bit compare).
  function automatic logic in_window(input logic [15:0] addr);
    logic [15:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && (off < 16'd4);
  endfunction

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic        bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic [15:0] addr_s1_q, addr_s2_q;
  logic [7:0]  data_s1_q, data_s2_q;
  logic        rw_s1_q, rw_s2_q;

  // BusClock flops reset to 1 so a strobe held high across reset release
  // cannot look like a rising edge; a fresh low-then-high is required.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bclk_s1_q <= 1'b1;
      bclk_s2_q <= 1'b1;
      bclk_s3_q <= 1'b1;
      addr_s1_q <= '0;
      addr_s2_q <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
      rw_s1_q   <= 1'b0;
      rw_s2_q   <= 1'b0;
    end else begin
      bclk_s1_q <= BusClock;
      bclk_s2_q <= bclk_s1_q;
      bclk_s3_q <= bclk_s2_q;
      addr_s1_q <= BusAddress;
      addr_s2_q <= addr_s1_q;
      data_s1_q <= BusData;
      data_s2_q <= data_s1_q;
      rw_s1_q   <= BusReadWrite;
      rw_s2_q   <= rw_s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic        bclk_rise;
  logic        commit;
  logic [15:0] wr_off;

  assign bclk_rise = bclk_s2_q & ~bclk_s3_q;
  assign wr_off    = addr_s2_q - BASE_ADDR;
  assign commit    = bclk_rise & rw_s2_q & in_window(addr_s2_q);

  // ---------------------------------------------------------------------------
  // Register file and event pulses
  // ---------------------------------------------------------------------------
  logic [7:0] incr_q, incr_d;
  logic       gate_q, gate_d;
  logic [1:0] wave_q, wave_d;
  logic [7:0] pw_q, pw_d;
  logic       gate_on_q, gate_on_d;
  logic       gate_off_q, gate_off_d;
  logic       strobe_q, strobe_d;

  always_comb begin
    incr_d     = incr_q;
    gate_d     = gate_q;
    wave_d     = wave_q;
    pw_d       = pw_q;
    gate_on_d  = 1'b0;
    gate_off_d = 1'b0;
    strobe_d   = commit;
    if (commit) begin
      unique case (wr_off[1:0])
        2'd0: incr_d = data_s2_q;
        2'd1: begin
          gate_d = data_s2_q[0];
          // Pulses only on an actual level change; rewriting the same value is silent.
          gate_on_d  = data_s2_q[0] & ~gate_q;
          gate_off_d = ~data_s2_q[0] & gate_q;
        end
        2'd2: wave_d = data_s2_q[1:0];
        2'd3: pw_d   = data_s2_q;
      endcase
    end
  end

  // Reset clears the gate without producing a GateOff pulse.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      incr_q     <= '0;
      gate_q     <= 1'b0;
      wave_q     <= '0;
      pw_q       <= PW_RESET;
      gate_on_q  <= 1'b0;
      gate_off_q <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      incr_q     <= incr_d;
      gate_q     <= gate_d;
      wave_q     <= wave_d;
      pw_q       <= pw_d;
      gate_on_q  <= gate_on_d;
      gate_off_q <= gate_off_d;
      strobe_q   <= strobe_d;
    end
  end

  assign Incr        = incr_q;
  assign Gate        = gate_q;
  assign WaveType    = wave_q;
  assign PulseWidth  = pw_q;
  assign GateOn      = gate_on_q;
  assign GateOff     = gate_off_q;
  assign WriteStrobe = strobe_q;

  // ---------------------------------------------------------------------------
  // Readback
  // ---------------------------------------------------------------------------
`ifdef VOICE_BUS_READBACK_EN
  logic [15:0] rd_off;
  logic [7:0]  rd_data;
  logic        rd_en;

  // Combinational from the raw bus: the initiator samples while BusClock is high.
  assign rd_off = BusAddress - BASE_ADDR;
  assign rd_en  = ~Reset & ~BusReadWrite & BusClock & in_window(BusAddress);

  always_comb begin
    rd_data = '0;
    unique case (rd_off[1:0])
      2'd0: rd_data = incr_q;
      2'd1: rd_data = {7'b0, gate_q};
      2'd2: rd_data = {6'b0, wave_q};
      2'd3: rd_data = pw_q;
    endcase
  end

  assign BusData = rd_en ? rd_data : 8'hzz;
`else
  assign BusData = 8'hzz;
`endif

endmodule
